// File: rtl/vid_pkg.sv
// Shared video definitions: BT.601 full-range coefficients and the sideband bundle
// that travels alongside each pixel through the conversion pipeline.
package vid_pkg;

  localparam int VID_FRAC = 8;

  localparam real K_RV = 1.402;
  localparam real K_GU = 0.344136;
  localparam real K_GV = 0.714136;
  localparam real K_BU = 1.772;

  // round(k * 2^frac) as an unsigned 10-bit coefficient
  function automatic logic [9:0] vid_coef(input real k, input int frac);
    return 10'($rtoi(k * real'(1 << frac) + 0.5));
  endfunction

  localparam logic [9:0] KRV = vid_coef(K_RV, VID_FRAC);
  localparam logic [9:0] KGU = vid_coef(K_GU, VID_FRAC);
  localparam logic [9:0] KGV = vid_coef(K_GV, VID_FRAC);
  localparam logic [9:0] KBU = vid_coef(K_BU, VID_FRAC);

  typedef struct packed {
    logic pce;
    logic hsn;
    logic vsn;
    logic hbl;
    logic vbl;
  } vid_sb_t;

  // Inactive sideband: no pixel enable, syncs deasserted, blanking active
  localparam vid_sb_t SB_IDLE = '{pce: 1'b0, hsn: 1'b1, vsn: 1'b1, hbl: 1'b1, vbl: 1'b1};

endpackage

// File: rtl/vid_clamp8.sv
// Combinational saturation of a signed 21-bit value into the unsigned 8-bit range 0..255.
module vid_clamp8 (
  input  logic signed [20:0] din,
  output logic        [7:0]  dout
);

  always_comb begin
    dout = din[7:0];
    if (din < 21'sd0) begin
      dout = 8'd0;
    end else if (din > 21'sd255) begin
      dout = 8'd255;
    end
  end

endmodule

// File: rtl/vid_yuv2rgb.sv
// Three-stage BT.601 full-range YUV to RGB converter; sideband is delayed in lockstep
// with the colour path so timing and pixels stay aligned at the output.
module vid_yuv2rgb
  import vid_pkg::*;
#(
  parameter int FRAC        = VID_FRAC,
  parameter bit BLANK_BLACK = 1'b1
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic       vid_pce,
  input  logic [7:0] vid_y,
  input  logic [7:0] vid_u,
  input  logic [7:0] vid_v,
  input  logic       vid_hsn,
  input  logic       vid_vsn,
  input  logic       vid_hbl,
  input  logic       vid_vbl,
  input  logic       bypass,
  output logic       ce_pix,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HSync,
  output logic       VSync,
  output logic       HBlank,
  output logic       VBlank
);

  localparam logic signed [19:0] C_RV = 20'(vid_coef(K_RV, FRAC));
  localparam logic signed [19:0] C_GU = 20'(vid_coef(K_GU, FRAC));
  localparam logic signed [19:0] C_GV = 20'(vid_coef(K_GV, FRAC));
  localparam logic signed [19:0] C_BU = 20'(vid_coef(K_BU, FRAC));

  // Stage 1 inputs
  logic signed [8:0]  u_off;
  logic signed [8:0]  v_off;
  logic signed [20:0] y8_next;
  vid_sb_t            sb_in;

  assign u_off   = $signed({1'b0, vid_u}) - 9'sd128;
  assign v_off   = $signed({1'b0, vid_v}) - 9'sd128;
  assign y8_next = $signed((21'(vid_y) << FRAC) + 21'(1 << (FRAC - 1)));
  assign sb_in   = '{pce: vid_pce, hsn: vid_hsn, vsn: vid_vsn, hbl: vid_hbl, vbl: vid_vbl};

  logic signed [20:0] y8_reg;
  logic signed [19:0] p_rv_reg, p_gu_reg, p_gv_reg, p_bu_reg;
  logic        [7:0]  raw1_reg [3];
  logic               byp1_reg;
  vid_sb_t            sb1_reg;

  logic signed [20:0] sum_next [3];
  logic signed [20:0] sum_reg  [3];
  logic        [7:0]  raw2_reg [3];
  logic               byp2_reg;
  vid_sb_t            sb2_reg;

  always_comb begin
    sum_next[0] = y8_reg + 21'(p_rv_reg);
    sum_next[1] = y8_reg - 21'(p_gu_reg) - 21'(p_gv_reg);
    sum_next[2] = y8_reg + 21'(p_bu_reg);
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      y8_reg   <= '0;
      p_rv_reg <= '0;
      p_gu_reg <= '0;
      p_gv_reg <= '0;
      p_bu_reg <= '0;
      raw1_reg <= '{default: '0};
      byp1_reg <= 1'b0;
      sb1_reg  <= SB_IDLE;
      sum_reg  <= '{default: '0};
      raw2_reg <= '{default: '0};
      byp2_reg <= 1'b0;
      sb2_reg  <= SB_IDLE;
    end else begin
      y8_reg   <= y8_next;
      p_rv_reg <= 20'(v_off) * C_RV;
      p_gu_reg <= 20'(u_off) * C_GU;
      p_gv_reg <= 20'(v_off) * C_GV;
      p_bu_reg <= 20'(u_off) * C_BU;
      // Debug bypass routes R=U, G=Y, B=V
      raw1_reg <= '{vid_u, vid_y, vid_v};
      byp1_reg <= bypass;
      sb1_reg  <= sb_in;
      sum_reg  <= sum_next;
      raw2_reg <= raw1_reg;
      byp2_reg <= byp1_reg;
      sb2_reg  <= sb1_reg;
    end
  end

  logic       blank2;
  logic [7:0] rgb [3];

  assign blank2 = sb2_reg.hbl | sb2_reg.vbl;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] clamped;
      logic [7:0] chan_next;
      logic [7:0] chan_reg;

      vid_clamp8 u_clamp (
        .din  (sum_reg[gi] >>> FRAC),
        .dout (clamped)
      );

      always_comb begin
        chan_next = byp2_reg ? raw2_reg[gi] : clamped;
        if (BLANK_BLACK && blank2) begin
          chan_next = 8'd0;
        end
      end

      always_ff @(posedge clk_cpu) begin
        if (reset) begin
          chan_reg <= 8'd0;
        end else begin
          chan_reg <= chan_next;
        end
      end

      assign rgb[gi] = chan_reg;
    end
  endgenerate

  assign R = rgb[0];
  assign G = rgb[1];
  assign B = rgb[2];

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      ce_pix <= 1'b0;
      HSync  <= 1'b0;
      VSync  <= 1'b0;
      HBlank <= 1'b1;
      VBlank <= 1'b1;
    end else begin
      ce_pix <= sb2_reg.pce;
      HSync  <= ~sb2_reg.hsn;
      VSync  <= ~sb2_reg.vsn;
      HBlank <= sb2_reg.hbl;
      VBlank <= sb2_reg.vbl;
    end
  end

endmodule

// File: tb/tb_vid_yuv2rgb.sv
// Bench for vid_yuv2rgb: directed BT.601 cases, blanking, bypass and reset scenarios, then
// random traffic, all checked against an arithmetic reference applied three cycles later.
module tb_vid_yuv2rgb;

  logic       clk_cpu = 1'b0;
  logic       reset;
  logic       vid_pce;
  logic [7:0] vid_y, vid_u, vid_v;
  logic       vid_hsn, vid_vsn, vid_hbl, vid_vbl;
  logic       bypass;

  logic       ce_pix, HSync, VSync, HBlank, VBlank;
  logic [7:0] R, G, B;
  logic       ce_pix_nb, HSync_nb, VSync_nb, HBlank_nb, VBlank_nb;
  logic [7:0] R_nb, G_nb, B_nb;

  always #5 clk_cpu = ~clk_cpu;

  vid_yuv2rgb #(.BLANK_BLACK(1'b1)) u_dut (
    .clk_cpu (clk_cpu), .reset (reset), .vid_pce (vid_pce),
    .vid_y (vid_y), .vid_u (vid_u), .vid_v (vid_v),
    .vid_hsn (vid_hsn), .vid_vsn (vid_vsn), .vid_hbl (vid_hbl), .vid_vbl (vid_vbl),
    .bypass (bypass), .ce_pix (ce_pix), .R (R), .G (G), .B (B),
    .HSync (HSync), .VSync (VSync), .HBlank (HBlank), .VBlank (VBlank)
  );

  vid_yuv2rgb #(.BLANK_BLACK(1'b0)) u_dut_nb (
    .clk_cpu (clk_cpu), .reset (reset), .vid_pce (vid_pce),
    .vid_y (vid_y), .vid_u (vid_u), .vid_v (vid_v),
    .vid_hsn (vid_hsn), .vid_vsn (vid_vsn), .vid_hbl (vid_hbl), .vid_vbl (vid_vbl),
    .bypass (bypass), .ce_pix (ce_pix_nb), .R (R_nb), .G (G_nb), .B (B_nb),
    .HSync (HSync_nb), .VSync (VSync_nb), .HBlank (HBlank_nb), .VBlank (VBlank_nb)
  );

  localparam int N = 2048;
  int h_y [N], h_u [N], h_v [N];
  bit h_pce [N], h_hsn [N], h_vsn [N], h_hbl [N], h_vbl [N], h_byp [N], h_rst [N];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  // BT.601 full range, 8 fractional bits, rounding pre-added to luma
  function automatic logic [23:0] ref_rgb(input int y, input int u, input int v,
                                          input bit byp, input bit black);
    int base;
    logic [7:0] r, g, b;
    if (black) return 24'd0;
    if (byp) return {u[7:0], y[7:0], v[7:0]};
    base = y * 256 + 128;
    r = sat8((base + (v - 128) * 359) >>> 8);
    g = sat8((base - (u - 128) * 88 - (v - 128) * 183) >>> 8);
    b = sat8((base + (u - 128) * 454) >>> 8);
    return {r, g, b};
  endfunction

  task automatic step(input int y, input int u, input int v, input bit pce,
                      input bit hsn, input bit vsn, input bit hbl, input bit vbl,
                      input bit byp, input bit rst);
    bit idle;
    int k;
    logic [23:0] e_rgb, e_rgb_nb;
    logic [3:0]  e_sync;
    logic        e_ce;
    reset = rst; vid_y = 8'(y); vid_u = 8'(u); vid_v = 8'(v); vid_pce = pce;
    vid_hsn = hsn; vid_vsn = vsn; vid_hbl = hbl; vid_vbl = vbl; bypass = byp;
    h_y[cyc] = y; h_u[cyc] = u; h_v[cyc] = v; h_pce[cyc] = pce; h_hsn[cyc] = hsn;
    h_vsn[cyc] = vsn; h_hbl[cyc] = hbl; h_vbl[cyc] = vbl; h_byp[cyc] = byp; h_rst[cyc] = rst;
    @(posedge clk_cpu);
    #1;
    idle = (cyc < 2);
    for (int i = 0; i < 3; i++) if (cyc - i >= 0 && h_rst[cyc - i]) idle = 1'b1;
    if (idle) begin
      e_ce = 1'b0; e_rgb = 24'd0; e_rgb_nb = 24'd0; e_sync = 4'b0011;
    end else begin
      k = cyc - 2;
      e_ce     = h_pce[k];
      e_sync   = {~h_hsn[k], ~h_vsn[k], h_hbl[k], h_vbl[k]};
      e_rgb    = ref_rgb(h_y[k], h_u[k], h_v[k], h_byp[k], h_hbl[k] | h_vbl[k]);
      e_rgb_nb = ref_rgb(h_y[k], h_u[k], h_v[k], h_byp[k], 1'b0);
    end
    $display("cyc %0d in Y=%0d U=%0d V=%0d pce=%0b byp=%0b rst=%0b -> RGB=%0d,%0d,%0d ce=%0b sync=%b",
             cyc, y, u, v, pce, byp, rst, R, G, B, ce_pix, {HSync, VSync, HBlank, VBlank});
    check_val("ce_pix", 32'(ce_pix), 32'(e_ce));
    check_val("rgb", 32'({R, G, B}), 32'(e_rgb));
    check_val("sync_blank", 32'({HSync, VSync, HBlank, VBlank}), 32'(e_sync));
    check_val("rgb_noblack", 32'({R_nb, G_nb, B_nb}), 32'(e_rgb_nb));
    cyc++;
  endtask

  initial begin
    // Reset, then release with idle input
    for (int i = 0; i < 3; i++) step(0, 128, 128, 0, 1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(128, 128, 128, 1, 1, 1, 0, 0, 0, 0);
    step(255, 128, 255, 1, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    step(81, 90, 240, 1, 1, 1, 0, 0, 0, 0);
    step(81, 90, 240, 1, 1, 1, 0, 0, 1, 0);
    // Bypass toggling pixel by pixel
    for (int i = 0; i < 6; i++) step(81, 90, 240, i % 2, 1, 1, 0, 0, (i % 3) == 1, 0);
    // Five-cycle horizontal blank/sync window on mid-grey
    for (int i = 0; i < 9; i++) begin
      if (i >= 2 && i < 7) step(128, 128, 128, 1, 0, 1, 1, 0, 0, 0);
      else                 step(128, 128, 128, 1, 1, 1, 0, 0, 0, 0);
    end
    // Single-cycle reset in the middle of a continuous pixel stream
    for (int i = 0; i < 8; i++) step(100 + i, 60, 200, 1, 1, 1, 0, 0, 0, i == 3);
    // Random traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(255), $urandom_range(255), $urandom_range(255),
           1'($urandom_range(1)), $urandom_range(7) != 0, $urandom_range(15) != 0,
           $urandom_range(5) == 0, $urandom_range(9) == 0, $urandom_range(3) == 0,
           $urandom_range(63) == 0);
    end
    // Drain
    for (int i = 0; i < 3; i++) step(128, 128, 128, 0, 1, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
